// File: rtl/avg_channel_arbiter.sv
// Round-robin arbitrated windowed averager shared by CHANNELS sample producers.
// Optional `define AVG_ARB_PRIO0_EN gives channel 0 fixed highest priority.
module avg_channel_arbiter #(
  parameter int WIDTH    = 8,
  parameter int SIZE     = 4,
  parameter int CHANNELS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           req_valid,
  input  logic [CHANNELS*WIDTH-1:0]     req_data,
  output logic [CHANNELS-1:0]           req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CHANNELS)-1:0]   out_channel,
  output logic [WIDTH-1:0]              out_average
);

  localparam int CNT_SIZE  = $clog2(SIZE);
  localparam int SUMM_SIZE = WIDTH + CNT_SIZE;
  localparam int CH_W      = $clog2(CHANNELS);

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } slot_e;

  slot_e                        r_state;
  slot_e                        w_state_nxt;

  logic signed [SUMM_SIZE-1:0]  r_summ [CHANNELS];
  logic        [CNT_SIZE-1:0]   r_cnt  [CHANNELS];
  logic        [CH_W-1:0]       r_rr_ptr;
  logic        [CH_W-1:0]       r_out_channel;
  logic        [WIDTH-1:0]      r_out_average;

  logic                         w_slot_free;
  logic        [CHANNELS-1:0]   w_elig;
  logic        [CHANNELS-1:0]   w_grant;
  logic                         w_found;
  logic        [CH_W-1:0]       w_gidx;
  logic        [CH_W-1:0]       w_pos;
  logic                         w_accept;
  logic                         w_final;
  logic                         w_rr_upd;
  logic        [CH_W-1:0]       w_rr_next;
  logic        [WIDTH-1:0]      w_sample;
  logic signed [SUMM_SIZE-1:0]  w_total;
  logic signed [SUMM_SIZE-1:0]  w_total_sh;

  assign out_valid   = (r_state == S_FULL);
  assign out_channel = r_out_channel;
  assign out_average = r_out_average;
  assign w_slot_free = !out_valid || out_ready;

  // A channel about to complete its window may only be granted when the
  // output slot can take the result this cycle; other channels never stall.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_elig[i] = req_valid[i] &&
                  ((r_cnt[i] != CNT_SIZE'(SIZE - 1)) || w_slot_free);
    end
  end

  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_pos   = '0;
`ifdef AVG_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_found = 1'b1;
      w_gidx  = '0;
    end
`endif
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_pos = CH_W'((32'(r_rr_ptr) + k) % CHANNELS);
      if (!w_found && w_elig[w_pos]) begin
        w_found = 1'b1;
        w_gidx  = w_pos;
      end
    end
    if (reset) begin
      w_found = 1'b0;
    end
    w_grant[w_gidx] = w_found;
  end

  assign req_ready = w_grant;
  assign w_accept  = w_found;
  assign w_final   = w_accept && (r_cnt[w_gidx] == CNT_SIZE'(SIZE - 1));

`ifdef AVG_ARB_PRIO0_EN
  // Priority grants to channel 0 leave the rotation untouched.
  assign w_rr_upd = w_accept && (w_gidx != '0);
`else
  assign w_rr_upd = w_accept;
`endif

  assign w_rr_next  = (w_gidx == CH_W'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
  assign w_sample   = req_data[w_gidx*WIDTH +: WIDTH];
  assign w_total    = r_summ[w_gidx] + {{CNT_SIZE{w_sample[WIDTH-1]}}, w_sample};
  assign w_total_sh = w_total >>> CNT_SIZE;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_final) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        if (w_final)        w_state_nxt = S_FULL;
        else if (out_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_channel <= '0;
      r_out_average <= '0;
    end else if (w_final) begin
      r_out_channel <= w_gidx;
      r_out_average <= w_total_sh[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_rr_upd) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_summ[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (w_accept) begin
      if (w_final) begin
        r_summ[w_gidx] <= '0;
        r_cnt[w_gidx]  <= '0;
      end else begin
        r_summ[w_gidx] <= w_total;
        r_cnt[w_gidx]  <= r_cnt[w_gidx] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avg_channel_arbiter.sv
// Scoreboard bench for avg_channel_arbiter (CHANNELS=4, SIZE=4, WIDTH=8).
// Honours `define AVG_ARB_PRIO0_EN to select the fixed-priority scenario.
module tb_avg_channel_arbiter;

  localparam int W = 8;
  localparam int S = 4;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   req_valid;
  logic [C*W-1:0] req_data;
  logic [C-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_channel;
  logic [W-1:0]   out_average;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] avg;
  } exp_t;

  exp_t sb[$];

  avg_channel_arbiter #(.WIDTH(W), .SIZE(S), .CHANNELS(C)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_average (out_average)
  );

  always #5 clk = ~clk;

  // Every consumed average must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ch=%0d avg=%0d, required no output", out_channel, $signed(out_average));
      end else begin
        e = sb.pop_front();
        if ({out_channel, out_average} !== e) begin
          errors++;
          $display("FAIL sb_output: got ch=%0d avg=%0d, required ch=%0d avg=%0d",
                   out_channel, $signed(out_average), e.ch, $signed(e.avg));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++;
    if ({out_valid, out_channel, out_average} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ch=%0d avg=%0d, required all 0", out_valid, out_channel, out_average);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single_ramp();
    int s[4] = '{1, 2, 3, 6};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0100;
      req_data[2*W +: W] = 8'(s[k]);
      if (k == 3) sb.push_back({2'd2, 8'd3});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ramp_grant%0d: got ready=%b valid=%b, required 0100 valid=0", k, req_ready, out_valid);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd2 || out_average !== 8'd3) begin
      errors++;
      $display("FAIL ramp_out: got v=%b ch=%0d avg=%0d, required v=1 ch=2 avg=3", out_valid, out_channel, out_average);
    end
  endtask

  task automatic test_negative_floor();
    int s[4] = '{-1, -1, -1, -2};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_data[0 +: W] = 8'(s[k]);
      if (k == 3) sb.push_back({2'd0, 8'hFE});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL floor_grant%0d: got %b, required 0001", k, req_ready);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_average !== 8'hFE) begin
      errors++;
      $display("FAIL floor_out: got v=%b avg=%0d, required v=1 avg=-2", out_valid, $signed(out_average));
    end
  endtask

  task automatic test_fairness();
    int n[4]       = '{0, 0, 0, 0};
    int exp_avg[4] = '{11, 21, 31, -42};
    int g;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      g = c % 4;
      @(posedge clk); #1;
      req_valid = '1;
      for (int i = 0; i < 4; i++) begin
        req_data[i*W +: W] = (i < 3) ? 8'((i + 1) * 10 + n[i]) : 8'(-(40 + n[i]));
      end
      if (n[g] == 3) sb.push_back({2'(g), 8'(exp_avg[g])});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << g)) begin
        errors++;
        $display("FAIL fair_grant%0d: got %b, required %b", c, req_ready, 4'(1 << g));
      end
      n[g]++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fair_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_data[0 +: W] = 8'd8;
      if (k == 3) sb.push_back({2'd0, 8'd8});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_fill%0d: got %b, required 0001", k, req_ready); end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_data[W +: W] = 8'd4;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_nonfinal%0d: got ready=%b valid=%b, required 0010 valid=1", k, req_ready, out_valid);
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data[0 +: W] = 8'd1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ptr: got %b, required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0110;
    req_data[W +: W] = 8'd8;
    req_data[2*W +: W] = 8'd7;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_block: got %b, required 0100", req_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_average !== 8'd8) begin
      errors++;
      $display("FAIL bp_hold: got v=%b ch=%0d avg=%0d, required v=1 ch=0 avg=8", out_valid, out_channel, out_average);
    end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall: got %b, required 0000", req_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    sb.push_back({2'd1, 8'd5});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b, required 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd1 || out_average !== 8'd5) begin
      errors++;
      $display("FAIL bp_reload: got v=%b ch=%0d avg=%0d, required v=1 ch=1 avg=5", out_valid, out_channel, out_average);
    end
  endtask

  task automatic test_reset_mid_window();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      req_valid = 4'b1000;
      req_data[3*W +: W] = 8'd5;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_pre%0d: got %b, required 1000", k, req_ready); end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b, required 0000", req_ready); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_channel, out_average} !== 11'd0) begin
      errors++;
      $display("FAIL mid_outputs: got v=%b ch=%0d avg=%0d, required all 0", out_valid, out_channel, out_average);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1000;
      req_data[3*W +: W] = 8'd4;
      if (k == 3) sb.push_back({2'd3, 8'd4});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_feed%0d: got ready=%b valid=%b, required 1000 valid=0", k, req_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd3 || out_average !== 8'd4) begin
      errors++;
      $display("FAIL mid_out: got v=%b ch=%0d avg=%0d, required v=1 ch=3 avg=4", out_valid, out_channel, out_average);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_single: got v=%b, required 0", out_valid); end
  endtask

  task automatic test_prio0();
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    req_data = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL prio_setup: got %b, required 0100", req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = '1;
      req_data = {8'd9, 8'd9, 8'd9, 8'd2};
      if (k == 3) sb.push_back({2'd0, 8'd2});
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL prio_ch0_%0d: got %b, required 0001", k, req_ready); end
    end
    @(posedge clk); #1;
    req_valid = 4'b1110;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL prio_resume: got %b, required 1000", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL prio_wrap: got %b, required 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_ramp();
    test_negative_floor();
`ifdef AVG_ARB_PRIO0_EN
    test_prio0();
`else
    test_fairness();
`endif
    test_backpressure();
    test_reset_mid_window();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
